// File: rtl/adaptive_threshold.sv
// ============================================================================
// Module   : adaptive_threshold
// Purpose  : Second pass of adaptive thresholding. Walks the source-image and
//            3x3-mean memories in raster order and writes 0/255 per pixel,
//            depending on whether the pixel exceeds (mean - OFFSET).
// Ports    : clock/reset      - clock, asynchronous active-high reset
//            start            - level, box-filter pass completed
//            oReadCol/oReadRow- shared read address for image and mean memories
//            iImageData       - source pixel (1-cycle synchronous read)
//            iMeanData        - local mean   (1-cycle synchronous read)
//            oResultCol/Row   - write address
//            oResultData      - binary pixel, 0 or 255
//            oResultWren      - one write strobe per pixel
//            busy             - high in RUN and DRAIN
//            finished         - sticky completion flag
// Options  : ADAPTIVE_THRESHOLD_INVERT_EN - when defined, output polarity is
//            inverted (dark foreground reads as 255).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adaptive_threshold #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int WIDTH       = 2**WIDTH_BITS,
  parameter int HEIGHT      = 2**HEIGHT_BITS,
  parameter int OFFSET      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic [WIDTH_BITS-1:0]  oReadCol,
  output logic [HEIGHT_BITS-1:0] oReadRow,
  input  logic [7:0]             iImageData,
  input  logic [7:0]             iMeanData,
  output logic [WIDTH_BITS-1:0]  oResultCol,
  output logic [HEIGHT_BITS-1:0] oResultRow,
  output logic [7:0]             oResultData,
  output logic                   oResultWren,
  output logic                   busy,
  output logic                   finished
);

  localparam int              C_PW   = WIDTH_BITS + HEIGHT_BITS;
  localparam int              C_N    = WIDTH * HEIGHT;
  localparam logic [C_PW-1:0] C_LAST = C_PW'(C_N - 1);
  localparam logic signed [9:0] C_OFF = 10'(OFFSET);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [C_PW-1:0]  r_pos;
  logic             r_drain;
  logic             r_v1;
  logic [C_PW-1:0]  r_a1;

  logic signed [9:0] w_thr;
  logic signed [9:0] w_pix;
  logic              w_above;
  logic [7:0]        w_result;

  // Read address is the registered raster position; col in the low bits.
  assign oReadCol = r_pos[WIDTH_BITS-1:0];
  assign oReadRow = r_pos[C_PW-1:WIDTH_BITS];

  // 10-bit signed arithmetic: a mean below OFFSET gives a negative threshold
  // instead of wrapping, so every pixel counts as above it.
  always_comb begin
    w_thr   = $signed({2'b00, iMeanData}) - C_OFF;
    w_pix   = $signed({2'b00, iImageData});
    w_above = (w_pix > w_thr);
`ifdef ADAPTIVE_THRESHOLD_INVERT_EN
    w_result = w_above ? 8'd0 : 8'd255;
`else
    w_result = w_above ? 8'd255 : 8'd0;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pos       <= '0;
      r_drain     <= 1'b0;
      r_v1        <= 1'b0;
      r_a1        <= '0;
      oResultCol  <= '0;
      oResultRow  <= '0;
      oResultData <= '0;
      oResultWren <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
    end else begin
      // Stage 1: the address issued this cycle lines up with next cycle's data.
      r_v1 <= (r_state == S_RUN);
      r_a1 <= r_pos;

      // Stage 2: compare and write back at the aligned address.
      oResultWren <= r_v1;
      if (r_v1) begin
        oResultCol  <= r_a1[WIDTH_BITS-1:0];
        oResultRow  <= r_a1[C_PW-1:WIDTH_BITS];
        oResultData <= w_result;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_pos   <= '0;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_pos == C_LAST) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
          end else begin
            r_pos <= r_pos + C_PW'(1);
          end
        end
        S_DRAIN: begin
          // Two cycles here flush both pipeline stages.
          if (r_drain) begin
            r_state  <= S_DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adaptive_threshold.sv
`default_nettype none

module tb_adaptive_threshold;

  localparam int WB  = 2;
  localparam int HB  = 2;
  localparam int N   = 16;
  localparam int OFS = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [WB-1:0] oReadCol;
  logic [HB-1:0] oReadRow;
  logic [7:0]    iImageData;
  logic [7:0]    iMeanData;
  logic [WB-1:0] oResultCol;
  logic [HB-1:0] oResultRow;
  logic [7:0]    oResultData;
  logic          oResultWren;
  logic          busy;
  logic          finished;

  adaptive_threshold #(
    .WIDTH_BITS (WB),
    .HEIGHT_BITS(HB),
    .OFFSET     (OFS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .oReadCol   (oReadCol),
    .oReadRow   (oReadRow),
    .iImageData (iImageData),
    .iMeanData  (iMeanData),
    .oResultCol (oResultCol),
    .oResultRow (oResultRow),
    .oResultData(oResultData),
    .oResultWren(oResultWren),
    .busy       (busy),
    .finished   (finished)
  );

  always #5 clock = ~clock;

  // Synchronous-read memories with one cycle of latency.
  logic [7:0] img_mem  [N];
  logic [7:0] mean_mem [N];
  int         exp_data [N];

  always @(posedge clock) begin
    iImageData <= img_mem[{oReadRow, oReadCol}];
    iMeanData  <= mean_mem[{oReadRow, oReadCol}];
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: binarise by the stated rule with plain integer arithmetic.
  function automatic int ref_pixel(input int img, input int mean);
    int r;
    r = (img > (mean - OFS)) ? 255 : 0;
`ifdef ADAPTIVE_THRESHOLD_INVERT_EN
    r = 255 - r;
`endif
    return r;
  endfunction

  function automatic int pol(input int v);
`ifdef ADAPTIVE_THRESHOLD_INVERT_EN
    return 255 - v;
`else
    return v;
`endif
  endfunction

  typedef struct {
    int img;
    int mean;
    int exp;   // non-inverted expected result
  } vec_t;

  vec_t tbl[N];

  task automatic do_reset();
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Start a frame and watch every cycle: addresses, write order and timing,
  // busy/finished edges. Writes for address k are due in cycle k+2.
  task automatic run_frame(input string tag);
    int nxt;
    int addr;
    nxt = 0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);  // E0
    for (int c = 0; c < N + 6; c++) begin
      @(negedge clock);  // inside cycle c
      if (c < N)
        chk($sformatf("%s rdaddr c%0d", tag, c), int'({oReadRow, oReadCol}), c);
      chk($sformatf("%s busy c%0d", tag, c), int'(busy), (c <= N + 1) ? 1 : 0);
      chk($sformatf("%s finished c%0d", tag, c), int'(finished), (c >= N + 2) ? 1 : 0);
      if (oResultWren) begin
        addr = int'({oResultRow, oResultCol});
        chk($sformatf("%s wr addr c%0d", tag, c), addr, nxt);
        chk($sformatf("%s wr cycle a%0d", tag, nxt), c, nxt + 2);
        if (nxt < N)
          chk($sformatf("%s wr data a%0d", tag, nxt), int'(oResultData), exp_data[nxt]);
        nxt++;
      end else if (c >= 2 && c <= N + 1) begin
        chk($sformatf("%s missing write c%0d", tag, c), 0, 1);
      end
    end
    chk($sformatf("%s write count", tag), nxt, N);
  endtask

  task automatic load_table();
    for (int i = 0; i < N; i++) begin
      img_mem[i]  = 8'(tbl[i].img);
      mean_mem[i] = 8'(tbl[i].mean);
      exp_data[i] = pol(tbl[i].exp);
    end
  endtask

  initial begin
    tbl[0]  = '{100, 100, 255};
    tbl[1]  = '{92,  100, 0};    // equal to threshold
    tbl[2]  = '{93,  100, 255};  // one above threshold
    tbl[3]  = '{0,   3,   255};  // negative threshold must not wrap
    tbl[4]  = '{0,   8,   0};    // threshold exactly 0
    tbl[5]  = '{1,   8,   255};
    tbl[6]  = '{255, 255, 255};
    tbl[7]  = '{247, 255, 0};
    tbl[8]  = '{248, 255, 255};
    tbl[9]  = '{0,   0,   255};
    tbl[10] = '{255, 0,   255};
    tbl[11] = '{0,   255, 0};
    tbl[12] = '{50,  200, 0};
    tbl[13] = '{200, 50,  255};
    tbl[14] = '{0,   7,   255};
    tbl[15] = '{99,  107, 0};
    for (int i = 0; i < N; i++) begin
      img_mem[i]  = 8'd100;
      mean_mem[i] = 8'd100;
    end

    // Reset state and idle hold.
    do_reset();
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      chk($sformatf("idle wren c%0d", c), int'(oResultWren), 0);
      chk($sformatf("idle busy c%0d", c), int'(busy), 0);
      chk($sformatf("idle finished c%0d", c), int'(finished), 0);
      chk($sformatf("idle rdaddr c%0d", c), int'({oReadRow, oReadCol}), 0);
      chk($sformatf("idle wraddr c%0d", c), int'({oResultRow, oResultCol}), 0);
    end

    // Uniform frame: image = mean = 100.
    for (int i = 0; i < N; i++) exp_data[i] = ref_pixel(100, 100);
    run_frame("uniform");

    // Table-driven frame covering the threshold boundaries.
    do_reset();
    load_table();
    run_frame("table");

    // Sticky done: start toggling must not restart anything.
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      start = ~start;
      chk($sformatf("sticky wren c%0d", c), int'(oResultWren), 0);
      chk($sformatf("sticky finished c%0d", c), int'(finished), 1);
      chk($sformatf("sticky busy c%0d", c), int'(busy), 0);
    end

    // Mid-run reset at cycle 7, then a clean restart.
    do_reset();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    repeat (8) @(negedge clock);  // now inside cycle 7
    start = 1'b0;
    reset = 1'b1;
    #1;
    chk("midreset wren", int'(oResultWren), 0);
    chk("midreset busy", int'(busy), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk($sformatf("midreset hold wren c%0d", c), int'(oResultWren), 0);
    end
    reset = 1'b0;
    run_frame("restart");

    // Randomised frames against the reference model, half near threshold.
    for (int f = 0; f < 4; f++) begin
      int m;
      int p;
      do_reset();
      for (int i = 0; i < N; i++) begin
        m = int'($urandom_range(0, 255));
        if ((f % 2) == 1) begin
          p = m - OFS + int'($urandom_range(0, 4)) - 2;
          if (p < 0) p = 0;
          if (p > 255) p = 255;
        end else begin
          p = int'($urandom_range(0, 255));
        end
        img_mem[i]  = 8'(p);
        mean_mem[i] = 8'(m);
        exp_data[i] = ref_pixel(p, m);
      end
      run_frame($sformatf("rand%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adaptive_threshold.md
# adaptive_threshold

Second pass of the adaptive-thresholding pipeline: reads the source image memory and the 3x3 mean memory, filled by the box-filter pass, in raster order over the same coordinate space. Compares each pixel against its local mean minus a fixed offset and writes a binary pixel (0 or 255) to the output memory at the same coordinates. Starts when the box-filter pass signals completion, processes one pixel per clock, then raises a sticky `finished`.

## Interface
Parameters:
- `WIDTH_BITS`, default 8: column address width.
- `HEIGHT_BITS`, default 8: row address width.
- `WIDTH`, default 2**WIDTH_BITS: image width in pixels.
- `HEIGHT`, default 2**HEIGHT_BITS: image height in pixels.
- `OFFSET`, default 8: constant C subtracted from the mean; range 0..255.

Ports:
- One clock; reset is asynchronous and active-high.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; connected to the box-filter `finished`.
- `oReadCol`  out  WIDTH_BITS  column address, shared by the image and mean memories.
- `oReadRow`  out  HEIGHT_BITS  row address, shared by both memories.
- `iImageData`  in  8  source pixel; synchronous read, 1-cycle latency.
- `iMeanData`  in  8  mean value; synchronous read, 1-cycle latency.
- `oResultCol`  out  WIDTH_BITS  write column.
- `oResultRow`  out  HEIGHT_BITS  write row.
- `oResultData`  out  8  binary pixel, 0 or 255.
- `oResultWren`  out  1  output-memory write strobe, one cycle per pixel.
- `busy`  out  1  high in RUN and DRAIN.
- `finished`  out  1  sticky completion flag.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when `start` is sampled high. The read position `pos` is 0.
- RUN: the read address is `pos`, with col = pos[WIDTH_BITS-1:0] and row = the upper bits. `pos` increments by 1 every cycle.
- RUN -> DRAIN on the cycle that issues `pos = WIDTH*HEIGHT-1`.
- DRAIN: holds for exactly 2 cycles so the 2-stage pipeline empties. The read address holds at the last pixel.
- DRAIN -> DONE.
- DONE: terminal until reset. `start` is ignored; `finished` = 1, `busy` = 0.
- Pipeline stage 1: the issued address is delayed one cycle to align with the returning memory data.
- Pipeline stage 2:
  - Compute `thr = $signed({2'b0,iMeanData}) - OFFSET` (10-bit signed).
  - Result is 255 if `iImageData > thr`, else 0.
  - If the mean < OFFSET, `thr` is negative and the result is always 255. The arithmetic must not wrap.
  - Register the result with its aligned address and `oResultWren` = 1.
- Every address is written exactly once, in raster order, with no gaps and no duplicates.
- Reset values: all outputs are 0, the state is IDLE and `pos` = 0.
- Reset mid-operation aborts immediately with no further writes. The block restarts on the next `start` high.

## Timing
- Start edge E0 is the edge at which `start` is sampled high in IDLE.
- Address k is driven during cycle k, the cycle after edge E(k).
- Data for address k returns during cycle k+1.
- `oResultWren` = 1 with result address k during cycle k+2: write latency 2, throughput 1 pixel per clock.
- For N = WIDTH*HEIGHT:
  - The last write strobe is during cycle N+1.
  - `finished` rises at edge E(N+2), in the same edge that drops `oResultWren`.
  - `busy` falls in the same edge.
- `busy` rises at E0.
- No backpressure: the output memory accepts one write per cycle.

## Configuration
- Macro `ADAPTIVE_THRESHOLD_INVERT_EN`.
- Defined: output polarity is inverted. The result is 0 if `iImageData > thr`, else 255, so dark foreground reads as 255.
- Undefined: polarity as in Operation.
- Timing, addressing and FSM are identical in both builds.

## Test plan
- **Idle hold:** `start` = 0 for 50 cycles after reset -> `oResultWren`, `busy` and `finished` stay 0, and the addresses stay 0.
- **Full frame:** 4x4 (WIDTH_BITS = HEIGHT_BITS = 2), image = mean = 100, OFFSET = 8, `start` high:
  - 16 writes at addresses 0..15, each with data 255.
  - Writes occur in cycles 2..17 after E0.
  - `finished` rises at E18.
- **Threshold edge:** mean 100, OFFSET 8:
  - pixel 92 -> 0.
  - pixel 93 -> 255.
  - mean 3, pixel 0 -> 255 (negative threshold, no wrap).
- **Invert build:** `ADAPTIVE_THRESHOLD_INVERT_EN` defined, mean 100, pixel 93 -> 0 and pixel 92 -> 255, with identical write cycles.
- **Mid-run reset:** assert `reset` at cycle 7 of a 4x4 run, then `start` again:
  - Writes stop immediately.
  - The restart writes addresses 0..15 exactly once each.
  - `finished` rises at E18 of the new run.
- **Sticky done:** toggle `start` after `finished` -> no further writes and `finished` stays 1.
